// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Eight-digit seven-segment scan controller. Accepts an 8-bit
//            binary value over valid/ready and converts it to three BCD
//            digits with a sequential shift-add-3 (double-dabble) engine.
//            The result is latched into a display buffer, and the buffer is
//            time-multiplexed across eight active-low anodes.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            in_data/in_valid   - value to display and its valid strobe
//            in_ready           - high in IDLE; the controller accepts a value
//            blank_lz           - blank leading zeros of the 3-digit field
//            busy               - conversion in progress (CONV or LOAD)
//            num                - index of the digit being driven (0 = right)
//            AN                 - active-low one-hot anode select
//            digit_code         - BCD code for digit num, 15 = blank
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       blank_lz,
    output logic       busy,
    output logic [2:0] num,
    output logic [7:0] AN,
    output logic [3:0] digit_code
);

    localparam int c_PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(SCAN_DIV - 1);
    localparam logic [3:0] c_BLANK = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_busy;
    logic [7:0]             r_shift;
    logic [11:0]            r_bcd;      // {hundreds, tens, ones}
    logic [2:0]             r_iter;
    logic [3:0]             r_d0;
    logic [3:0]             r_d1;
    logic [3:0]             r_d2;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [2:0]             r_num;

    logic [11:0]            w_adj;
    logic [3:0]             w_code;

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // Each BCD nibble is corrected before the shift so that its doubled value
    // carries correctly into the next decade.
    assign w_adj = {add3_if_ge5(r_bcd[11:8]),
                    add3_if_ge5(r_bcd[7:4]),
                    add3_if_ge5(r_bcd[3:0])};

    // ------------------------------------------------------------------
    // Handshake / conversion FSM with registered in_ready and busy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_d0       <= '0;
            r_d1       <= '0;
            r_d2       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_shift    <= in_data;
                        r_bcd      <= '0;
                        r_iter     <= '0;
                        r_state    <= S_CONV;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_CONV: begin
                    // The 8-bit input bounds the result to 255, so the top
                    // accumulator bit never carries out.
                    r_bcd   <= {w_adj[10:0], r_shift[7]};
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_iter  <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_d2       <= r_bcd[11:8];
                    r_d1       <= r_bcd[7:4];
                    r_d0       <= r_bcd[3:0];
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Free-running digit scan; independent of the conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_num   <= '0;
        end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            r_num   <= r_num + 3'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Ones digit is never blanked so that a value of zero shows one "0".
    always_comb begin
        w_code = c_BLANK;
        case (r_num)
            3'd0:    w_code = r_d0;
            3'd1:    w_code = (blank_lz && (r_d2 == 4'd0) && (r_d1 == 4'd0)) ? c_BLANK : r_d1;
            3'd2:    w_code = (blank_lz && (r_d2 == 4'd0)) ? c_BLANK : r_d2;
            default: w_code = c_BLANK;
        endcase
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign num        = r_num;
    assign AN         = ~(8'd1 << r_num);
    assign digit_code = w_code;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl with SCAN_DIV = 4. The
//            expected display is computed from the decimal digits of the last
//            accepted value; the expected scan position from the number of
//            clock edges since reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_SCAN_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       blank_lz;
    logic       busy;
    logic [2:0] num;
    logic [7:0] AN;
    logic [3:0] digit_code;

    int n_cmp;
    int n_err;
    int edges;      // clock edges since reset release
    int cur_val;    // value the display buffer should hold

    seg_scan_ctrl #(.SCAN_DIV(c_SCAN_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .blank_lz   (blank_lz),
        .busy       (busy),
        .num        (num),
        .AN         (AN),
        .digit_code (digit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: decimal digit extraction and leading-zero blanking rules.
    function automatic int exp_code(input int val, input int n, input bit blz);
        int h, t, o;
        h = val / 100;
        t = (val / 10) % 10;
        o = val % 10;
        case (n)
            0:       return o;
            1:       return (blz && h == 0 && t == 0) ? 15 : t;
            2:       return (blz && h == 0) ? 15 : h;
            default: return 15;
        endcase
    endfunction

    function automatic int exp_num();
        return (edges / c_SCAN_DIV) % 8;
    endfunction

    task automatic check_scan(input int val, input bit blz);
        int n;
        n = exp_num();
        check("num", num, n);
        check("AN", AN, 255 ^ (1 << n));
        check("code", digit_code, exp_code(val, n, blz));
    endtask

    // One full frame of display checks.
    task automatic check_frame(input int val, input bit blz, input int cycles);
        blank_lz = blz;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_scan(val, blz);
        end
    endtask

    // Bounded wait for in_ready at a negedge.
    task automatic wait_ready();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    // Send a value and check handshake timing plus the buffer update latency.
    task automatic send(input int v);
        wait_ready();
        in_data  = v[7:0];
        in_valid = 1'b1;
        check("ready_c0", in_ready, 1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            check("ready", in_ready, (c == 10) ? 1 : 0);
            check("busy", busy, (c == 10) ? 0 : 1);
            check("code", digit_code, exp_code((c == 10) ? v : cur_val, exp_num(), blank_lz));
        end
        cur_val = v;
    endtask

    initial begin
        int v;
        bit b;
        n_cmp    = 0;
        n_err    = 0;
        cur_val  = 0;
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        blank_lz = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_num", num, 0);
        check("rst_AN", AN, 8'hFE);
        check("rst_code", digit_code, 0);
        rst_n = 1'b1;

        // Idle scanning
        check_frame(0, 1'b0, 40);

        // Directed values
        blank_lz = 1'b0;
        send(255);
        check_frame(255, 1'b0, 32);
        send(7);
        check_frame(7, 1'b1, 32);
        check_frame(7, 1'b0, 32);
        blank_lz = 1'b1;
        send(100);
        check_frame(100, 1'b1, 32);
        send(0);
        check_frame(0, 1'b1, 32);

        // Backpressure: 12 held on in_valid while 34 converts
        blank_lz = 1'b0;
        wait_ready();
        in_data  = 8'd34;
        in_valid = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1)  in_data = 8'd12;
            if (c == 11) in_valid = 1'b0;
            check("bp_ready", in_ready, (c == 10 || c >= 20) ? 1 : 0);
            check("bp_code", digit_code,
                  exp_code((c < 10) ? cur_val : ((c < 20) ? 34 : 12), exp_num(), 1'b0));
        end
        cur_val = 12;
        check_frame(12, 1'b0, 32);

        // Randomized values and blanking mode
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 255));
            b = 1'($urandom_range(0, 1));
            blank_lz = b;
            send(v);
            check_frame(v, b, 32);
        end

        // Reset in the middle of a conversion of 200
        blank_lz = 1'b0;
        wait_ready();
        in_data  = 8'd200;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_num", num, 0);
        check("mid_rst_AN", AN, 8'hFE);
        check("mid_rst_code", digit_code, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        cur_val = 0;
        check_frame(0, 1'b0, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
